// File: rtl/fixed_complex_mac.sv
// fixed_complex_mac
// Fixed-point complex multiply-accumulate. One stb/ack handshake accepts a
// bundle of four operand words and a conjugate flag. ACC_LEN products are
// summed, then the sum is rounded half-up, saturated and offered on a
// single output stb/ack handshake.
module fixed_complex_mac #(
   parameter int W       = 16,
   parameter int FRAC    = 15,
   parameter int OW      = 16,
   parameter int ACC_LEN = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  input_a_real,
   input  logic [W-1:0]  input_a_imag,
   input  logic [W-1:0]  input_b_real,
   input  logic [W-1:0]  input_b_imag,
   input  logic          input_conj,
   input  logic          input_ab_stb,
   output logic          input_ab_ack,
   output logic [OW-1:0] output_z_real,
   output logic [OW-1:0] output_z_imag,
   output logic          output_z_ovf,
   output logic          output_z_stb,
   input  logic          output_z_ack
);

   // Product width, single-sum width, accumulator width, count width.
   localparam int PW = 2 * W;
   localparam int SW = PW + 1;
   localparam int AW = PW + 1 + $clog2(ACC_LEN + 1);
   localparam int CW = $clog2(ACC_LEN + 1);

   // Rounding works one bit wider than the accumulator so the bias add
   // can never wrap.
   localparam logic signed [AW:0] RND_BIAS = (AW + 1)'(1) << (FRAC - 1);
   localparam logic signed [AW:0] SAT_MAX  = {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
   localparam logic signed [AW:0] SAT_MIN  = {{(AW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

   typedef enum logic [2:0] {
      ST_GET,
      ST_MUL,
      ST_ADD,
      ST_ACC,
      ST_RND,
      ST_PUT
   } state_t;

   state_t state_reg, state_next;

   logic signed [W-1:0]  ar_reg, ai_reg, br_reg, bi_reg;
   logic                 conj_reg;
   logic signed [PW-1:0] p_rr_reg, p_ii_reg, p_ri_reg, p_ir_reg;
   logic signed [SW-1:0] sum_reg [2];
   logic signed [AW-1:0] acc_reg [2];
   logic [CW-1:0]        count_reg;
   logic [CW-1:0]        count_inc;
   logic                 ack_reg;
   logic                 stb_reg;
   logic                 ovf_reg;
   logic [OW-1:0]        z_reg   [2];

   logic signed [SW-1:0] ext_rr, ext_ii, ext_ri, ext_ir;
   logic [OW-1:0]        rnd_val [2];
   logic                 rnd_sat [2];

   logic accept;
   logic consume;

   assign accept    = input_ab_stb && ack_reg;
   assign consume   = output_z_ack && stb_reg;
   assign count_inc = count_reg + CW'(1);

   assign ext_rr = SW'(p_rr_reg);
   assign ext_ii = SW'(p_ii_reg);
   assign ext_ri = SW'(p_ri_reg);
   assign ext_ir = SW'(p_ir_reg);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_GET;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode; an output is only left when it has been consumed.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_GET: if (accept) state_next = ST_MUL;
         ST_MUL: state_next = ST_ADD;
         ST_ADD: state_next = ST_ACC;
         ST_ACC: state_next = (count_inc == CW'(ACC_LEN)) ? ST_RND : ST_GET;
         ST_RND: state_next = ST_PUT;
         ST_PUT: if (consume) state_next = ST_GET;
         default: state_next = ST_GET;
      endcase
   end

   // Handshake flags are registered from the next state so ack is high
   // exactly while in GET and stb exactly while in PUT, both low in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_reg <= 1'b0;
         stb_reg <= 1'b0;
      end else begin
         ack_reg <= (state_next == ST_GET);
         stb_reg <= (state_next == ST_PUT);
      end
   end

   // Capture the operand bundle and its conjugate flag on acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ar_reg   <= '0;
         ai_reg   <= '0;
         br_reg   <= '0;
         bi_reg   <= '0;
         conj_reg <= 1'b0;
      end else if (state_reg == ST_GET && accept) begin
         ar_reg   <= $signed(input_a_real);
         ai_reg   <= $signed(input_a_imag);
         br_reg   <= $signed(input_b_real);
         bi_reg   <= $signed(input_b_imag);
         conj_reg <= input_conj;
      end
   end

   // Four full-width partial products.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_rr_reg <= '0;
         p_ii_reg <= '0;
         p_ri_reg <= '0;
         p_ir_reg <= '0;
      end else if (state_reg == ST_MUL) begin
         p_rr_reg <= ar_reg * br_reg;
         p_ii_reg <= ai_reg * bi_reg;
         p_ri_reg <= ar_reg * bi_reg;
         p_ir_reg <= ai_reg * br_reg;
      end
   end

   // Combine partial products; conjugating b flips the sign of bi.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_reg[0] <= '0;
         sum_reg[1] <= '0;
      end else if (state_reg == ST_ADD) begin
         if (conj_reg) begin
            sum_reg[0] <= ext_rr + ext_ii;
            sum_reg[1] <= ext_ir - ext_ri;
         end else begin
            sum_reg[0] <= ext_rr - ext_ii;
            sum_reg[1] <= ext_ri + ext_ir;
         end
      end
   end

   // Accumulate products; accumulator and count restart once the result is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_reg[0] <= '0;
         acc_reg[1] <= '0;
         count_reg  <= '0;
      end else if (state_reg == ST_ACC) begin
         acc_reg[0] <= acc_reg[0] + AW'(sum_reg[0]);
         acc_reg[1] <= acc_reg[1] + AW'(sum_reg[1]);
         count_reg  <= count_inc;
      end else if (state_reg == ST_PUT && consume) begin
         acc_reg[0] <= '0;
         acc_reg[1] <= '0;
         count_reg  <= '0;
      end
   end

   // Round half-up then saturate each component (0 = real, 1 = imag).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_round
         logic signed [AW:0] biased;
         logic signed [AW:0] shifted;
         logic               sat_hi;
         logic               sat_lo;

         assign biased  = (AW + 1)'(acc_reg[gi]) + RND_BIAS;
         assign shifted = biased >>> FRAC;
         assign sat_hi  = (shifted > SAT_MAX);
         assign sat_lo  = (shifted < SAT_MIN);

         // Select clipped or in-range value for this component.
         always_comb begin
            rnd_val[gi] = shifted[OW-1:0];
            if (sat_hi) begin
               rnd_val[gi] = SAT_MAX[OW-1:0];
            end else if (sat_lo) begin
               rnd_val[gi] = SAT_MIN[OW-1:0];
            end
         end

         assign rnd_sat[gi] = sat_hi | sat_lo;
      end
   endgenerate

   // Output registers load once per result and hold until the next one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z_reg[0] <= '0;
         z_reg[1] <= '0;
         ovf_reg  <= 1'b0;
      end else if (state_reg == ST_RND) begin
         z_reg[0] <= rnd_val[0];
         z_reg[1] <= rnd_val[1];
         ovf_reg  <= rnd_sat[0] | rnd_sat[1];
      end
   end

   assign input_ab_ack  = ack_reg;
   assign output_z_stb  = stb_reg;
   assign output_z_real = z_reg[0];
   assign output_z_imag = z_reg[1];
   assign output_z_ovf  = ovf_reg;

endmodule

// File: tb/tb_fixed_complex_mac.sv
// Directed bench: one instance with ACC_LEN=1 and one with ACC_LEN=4,
// sharing clock and reset.
module tb_fixed_complex_mac;

   localparam int W  = 16;
   localparam int OW = 16;

   logic clk;
   logic rst;

   logic [W-1:0]  a_re_1, a_im_1, b_re_1, b_im_1;
   logic          conj_1, ab_stb_1, ab_ack_1;
   logic [OW-1:0] z_re_1, z_im_1;
   logic          z_ovf_1, z_stb_1, z_ack_1;

   logic [W-1:0]  a_re_4, a_im_4, b_re_4, b_im_4;
   logic          conj_4, ab_stb_4, ab_ack_4;
   logic [OW-1:0] z_re_4, z_im_4;
   logic          z_ovf_4, z_stb_4, z_ack_4;

   int checks = 0;
   int errors = 0;

   fixed_complex_mac #(.W(16), .FRAC(15), .OW(16), .ACC_LEN(1)) u_mac1 (
      .clk(clk), .rst(rst),
      .input_a_real(a_re_1), .input_a_imag(a_im_1),
      .input_b_real(b_re_1), .input_b_imag(b_im_1),
      .input_conj(conj_1), .input_ab_stb(ab_stb_1), .input_ab_ack(ab_ack_1),
      .output_z_real(z_re_1), .output_z_imag(z_im_1), .output_z_ovf(z_ovf_1),
      .output_z_stb(z_stb_1), .output_z_ack(z_ack_1)
   );

   fixed_complex_mac #(.W(16), .FRAC(15), .OW(16), .ACC_LEN(4)) u_mac4 (
      .clk(clk), .rst(rst),
      .input_a_real(a_re_4), .input_a_imag(a_im_4),
      .input_b_real(b_re_4), .input_b_imag(b_im_4),
      .input_conj(conj_4), .input_ab_stb(ab_stb_4), .input_ab_ack(ab_ack_4),
      .output_z_real(z_re_4), .output_z_imag(z_im_4), .output_z_ovf(z_ovf_4),
      .output_z_stb(z_stb_4), .output_z_ack(z_ack_4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic ack_of(input int d);
      return (d == 1) ? ab_ack_1 : ab_ack_4;
   endfunction

   function automatic logic stb_of(input int d);
      return (d == 1) ? z_stb_1 : z_stb_4;
   endfunction

   // Wait for ack, present one bundle for exactly one accepting edge.
   task automatic send(input int d, input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] br, input logic [15:0] bi, input logic cj,
                       input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (ack_of(d) !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ackwait"}, 32'(n < 20), 32'd1);
      if (d == 1) begin
         a_re_1 = ar; a_im_1 = ai; b_re_1 = br; b_im_1 = bi; conj_1 = cj; ab_stb_1 = 1'b1;
      end else begin
         a_re_4 = ar; a_im_4 = ai; b_re_4 = br; b_im_4 = bi; conj_4 = cj; ab_stb_4 = 1'b1;
      end
      @(posedge clk);
      #1;
      ab_stb_1 = 1'b0;
      ab_stb_4 = 1'b0;
      $display("send %s dut%0d a=%h+%hj b=%h+%hj conj=%0d", tag, d, ar, ai, br, bi, cj);
   endtask

   // Count edges after acceptance until stb is seen; must be 4.
   task automatic wait_result(input int d, input string tag);
      int  n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         seen = stb_of(d);
      end
      chk({tag, "_latency"}, 32'(n), 32'd4);
   endtask

   // After a non-final bundle, no stb may appear before ack returns.
   task automatic expect_no_result(input int d, input string tag);
      int  n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (ack_of(d) !== 1'b1 && n < 20) begin
         @(negedge clk);
         seen = seen | stb_of(d);
         n++;
      end
      chk({tag, "_nostb"}, 32'(seen), 32'd0);
   endtask

   task automatic check_z(input int d, input string tag, input logic [15:0] re,
                          input logic [15:0] im, input logic ovf);
      if (d == 1) begin
         chk({tag, "_re"}, 32'(z_re_1), 32'(re));
         chk({tag, "_im"}, 32'(z_im_1), 32'(im));
         chk({tag, "_ovf"}, 32'(z_ovf_1), 32'(ovf));
         $display("result %s dut1 z=%h+%hj ovf=%0d", tag, z_re_1, z_im_1, z_ovf_1);
      end else begin
         chk({tag, "_re"}, 32'(z_re_4), 32'(re));
         chk({tag, "_im"}, 32'(z_im_4), 32'(im));
         chk({tag, "_ovf"}, 32'(z_ovf_4), 32'(ovf));
         $display("result %s dut4 z=%h+%hj ovf=%0d", tag, z_re_4, z_im_4, z_ovf_4);
      end
   endtask

   // Take the result; stb drops and input ack returns on the next cycle.
   task automatic consume(input int d, input string tag);
      if (d == 1) z_ack_1 = 1'b1; else z_ack_4 = 1'b1;
      @(posedge clk);
      #1;
      z_ack_1 = 1'b0;
      z_ack_4 = 1'b0;
      @(negedge clk);
      chk({tag, "_stb_drop"}, 32'(stb_of(d)), 32'd0);
      chk({tag, "_ack_back"}, 32'(ack_of(d)), 32'd1);
   endtask

   initial begin
      int bad;
      logic [15:0] hold_re, hold_im;
      logic        hold_ovf;

      rst = 1'b1;
      {a_re_1, a_im_1, b_re_1, b_im_1, conj_1, ab_stb_1, z_ack_1} = '0;
      {a_re_4, a_im_4, b_re_4, b_im_4, conj_4, ab_stb_4, z_ack_4} = '0;
      #2 rst = 1'b0;
      #1;
      chk("reset_stb", 32'(z_stb_1), 32'd0);
      chk("reset_ack", 32'(ab_ack_1), 32'd0);
      chk("reset_re", 32'(z_re_1), 32'd0);
      chk("reset_ovf", 32'(z_ovf_1), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("release_ack1", 32'(ab_ack_1), 32'd1);
      chk("release_ack4", 32'(ab_ack_4), 32'd1);

      // 1: (0.5+0.5j)*(0.5-0.5j) = 0.5
      send(1, 16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0, "t1");
      wait_result(1, "t1");
      check_z(1, "t1", 16'h4000, 16'h0000, 1'b0);
      consume(1, "t1");

      // 2: same operands conjugated = 0.5j
      send(1, 16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b1, "t2");
      wait_result(1, "t2");
      check_z(1, "t2", 16'h0000, 16'h4000, 1'b0);
      consume(1, "t2");

      // Half-LSB rounding: +0.5 LSB rounds up, -0.5 LSB rounds to 0.
      send(1, 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, "rnd_pos");
      wait_result(1, "rnd_pos");
      check_z(1, "rnd_pos", 16'h0001, 16'h0000, 1'b0);
      consume(1, "rnd_pos");
      send(1, 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, "rnd_neg");
      wait_result(1, "rnd_neg");
      check_z(1, "rnd_neg", 16'h0000, 16'h0000, 1'b0);
      consume(1, "rnd_neg");

      // Negative saturation: (-1-1j)*(~1-~1j) real ~ -2.0
      send(1, 16'h8000, 16'h8000, 16'h7FFF, 16'h8001, 1'b0, "sat_neg");
      wait_result(1, "sat_neg");
      check_z(1, "sat_neg", 16'h8000, 16'h0000, 1'b1);
      consume(1, "sat_neg");

      // 3: (-1)*(-1) = +1.0 saturates
      send(1, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, "t3");
      wait_result(1, "t3");
      check_z(1, "t3", 16'h7FFF, 16'h0000, 1'b1);

      // 4: stall the consumer for 10 cycles
      hold_re = z_re_1;
      hold_im = z_im_1;
      hold_ovf = z_ovf_1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (z_stb_1 !== 1'b1 || z_re_1 !== hold_re || z_im_1 !== hold_im ||
             z_ovf_1 !== hold_ovf || ab_ack_1 !== 1'b0) bad++;
      end
      chk("t4_stall_stable", 32'(bad), 32'd0);
      chk("t4_stall_re", 32'(z_re_1), 32'h7FFF);
      consume(1, "t4");
      chk("t4_hold_after", 32'(z_re_1), 32'h7FFF);

      // 5: ACC_LEN=4, four 0.25*0.25 products -> 0.25
      for (int i = 0; i < 3; i++) begin
         send(4, 16'h2000, 16'h0000, 16'h2000, 16'h0000, 1'b0, "t5_part");
         expect_no_result(4, "t5_part");
      end
      send(4, 16'h2000, 16'h0000, 16'h2000, 16'h0000, 1'b0, "t5_last");
      wait_result(4, "t5");
      check_z(4, "t5", 16'h2000, 16'h0000, 1'b0);
      consume(4, "t5");

      // 6: reset after two of four bundles discards the partial sum
      for (int i = 0; i < 2; i++) begin
         send(4, 16'h2000, 16'h0000, 16'h2000, 16'h0000, 1'b0, "t6_part");
         expect_no_result(4, "t6_part");
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_stb", 32'(z_stb_4), 32'd0);
      chk("t6_rst_re", 32'(z_re_4), 32'd0);
      chk("t6_rst_ack", 32'(ab_ack_4), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(4, 16'h2000, 16'h0000, 16'h2000, 16'h0000, 1'b0, "t6_new");
         expect_no_result(4, "t6_new");
      end
      send(4, 16'h2000, 16'h0000, 16'h2000, 16'h0000, 1'b0, "t6_last");
      wait_result(4, "t6");
      check_z(4, "t6", 16'h2000, 16'h0000, 1'b0);
      consume(4, "t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
